// File: rtl/lif_event_scheduler.sv
// lif_event_scheduler
// Time-multiplexed sequencer for one leaky-integrate-and-fire membrane.
// A round-robin arbiter picks weighted spike events from NUM_REQ requesters.
// Timestep leak operations are interleaved with those events.
// Each accumulate or leak passes through a threshold check, which can fire
// a one-cycle postsynaptic spike.
// Optional feature: define LIF_REFRACTORY_EN to add a refractory period
// after each fire. During that period events are accepted and discarded,
// and ticks count the period down.
//
// state     | meaning
// S_IDLE    | arbitrate: pending tick -> leak, else grant an event
// S_ACC     | saturating add of the latched weight into the membrane
// S_LEAK    | floor-at-zero subtraction of leak_factor
// S_CHECK   | compare against THRESHOLD, fire and reset membrane if reached
// S_REFRACT | (LIF_REFRACTORY_EN only) drain events, count ticks down to idle
module lif_event_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int MEMBRANE_WIDTH = 16,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int LEAK_WIDTH     = 8,
  parameter logic [MEMBRANE_WIDTH-1:0] THRESHOLD = 16'h8000,
  parameter logic [MEMBRANE_WIDTH-1:0] RESET_VAL = 16'h0000,
  parameter int REFRACT_TICKS  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*WEIGHT_WIDTH-1:0]  req_weight,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             tick,
  input  logic [LEAK_WIDTH-1:0]            leak_factor,
  output logic [MEMBRANE_WIDTH-1:0]        membrane,
  output logic                             spike_out,
  output logic                             busy,
  output logic                             tick_overrun
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || REFRACT_TICKS < 1 ||
      MEMBRANE_WIDTH <= WEIGHT_WIDTH || MEMBRANE_WIDTH <= LEAK_WIDTH) begin : g_bad_cfg
    $error("lif_event_scheduler: unsupported parameter combination");
  end

`ifdef LIF_REFRACTORY_EN
  localparam int CNT_W = $clog2(REFRACT_TICKS + 1);
  typedef enum logic [2:0] {S_IDLE, S_ACC, S_LEAK, S_CHECK, S_REFRACT} state_t;
  logic [CNT_W-1:0] refract_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_LEAK, S_CHECK} state_t;
`endif

  state_t                    state;
  logic [IDX_W-1:0]          rr_ptr;
  logic                      tick_pending;
  logic [WEIGHT_WIDTH-1:0]   weight_q;

  logic                      grant_found;
  logic [IDX_W-1:0]          grant_idx;
  logic [IDX_W:0]            cand;
  logic [WEIGHT_WIDTH-1:0]   grant_weight;
  logic                      grant_open;
  logic                      pend_track;
  logic [IDX_W-1:0]          rr_next;
  logic [MEMBRANE_WIDTH:0]   acc_sum;
  logic [MEMBRANE_WIDTH-1:0] acc_sat;
  logic [MEMBRANE_WIDTH-1:0] leak_ext;
  logic [MEMBRANE_WIDTH-1:0] leak_res;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Weight of the requester that wins this cycle.
  always_comb begin
    grant_weight = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDX_W'(k)) grant_weight = req_weight[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  // A tick seen in idle already wins over events, so the leak is never
  // delayed behind an event that arrives in the same cycle.
`ifdef LIF_REFRACTORY_EN
  assign grant_open = (state == S_IDLE && !tick_pending && !tick) || (state == S_REFRACT);
  assign pend_track = (state != S_REFRACT);
`else
  assign grant_open = (state == S_IDLE) && !tick_pending && !tick;
  assign pend_track = 1'b1;
`endif

  // One-hot grant, held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && grant_open && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign rr_next  = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
  assign acc_sum  = {1'b0, membrane} + {{(MEMBRANE_WIDTH+1-WEIGHT_WIDTH){1'b0}}, weight_q};
  assign acc_sat  = acc_sum[MEMBRANE_WIDTH] ? '1 : acc_sum[MEMBRANE_WIDTH-1:0];
  assign leak_ext = {{(MEMBRANE_WIDTH-LEAK_WIDTH){1'b0}}, leak_factor};
  assign leak_res = (membrane > leak_ext) ? membrane - leak_ext : '0;
  assign busy     = (state != S_IDLE);

  // Sequencer, membrane register and tick bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      membrane     <= RESET_VAL;
      spike_out    <= 1'b0;
      tick_pending <= 1'b0;
      tick_overrun <= 1'b0;
      rr_ptr       <= '0;
      weight_q     <= '0;
`ifdef LIF_REFRACTORY_EN
      refract_cnt  <= '0;
`endif
    end else begin
      spike_out <= 1'b0;
      if (pend_track) begin
        if (tick && tick_pending) tick_overrun <= 1'b1;
        if (tick) tick_pending <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (tick_pending || tick) begin
            // The tick that triggers this leak is consumed here; only a
            // fresh tick on top of an already pending one re-arms.
            tick_pending <= tick_pending && tick;
            state        <= S_LEAK;
          end else if (grant_found) begin
            weight_q <= grant_weight;
            rr_ptr   <= rr_next;
            state    <= S_ACC;
          end
        end
        S_ACC: begin
          membrane <= acc_sat;
          state    <= S_CHECK;
        end
        S_LEAK: begin
          membrane <= leak_res;
          state    <= S_CHECK;
        end
        S_CHECK: begin
          if (membrane >= THRESHOLD) begin
            membrane  <= RESET_VAL;
            spike_out <= 1'b1;
`ifdef LIF_REFRACTORY_EN
            refract_cnt <= CNT_W'(REFRACT_TICKS);
            state       <= S_REFRACT;
`else
            state       <= S_IDLE;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
`ifdef LIF_REFRACTORY_EN
        S_REFRACT: begin
          if (grant_found) rr_ptr <= rr_next;
          if (refract_cnt == '0) state <= S_IDLE;
          else if (tick) refract_cnt <= refract_cnt - CNT_W'(1);
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
